// File: rtl/mem_store_unit_pkg.sv
// mem_store_unit_pkg: store op codes, bus width and store-buffer entry layout
package mem_store_unit_pkg;
  localparam int REG_BUS = 64;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  typedef enum logic [2:0] {
    SZ_B = 3'b001,
    SZ_H = 3'b010,
    SZ_W = 3'b011,
    SZ_D = 3'b111
  } st_op_e;
  typedef struct packed {
    logic [REG_BUS-1:0] addr;
    logic [REG_BUS-1:0] data;
    logic [7:0]         mask;
  } sb_entry_t;
endpackage

// File: rtl/mem_store_unit_if.sv
// mem_store_unit_if: store request bus (st_*) and doubleword write port (mem_w_*)
// slave = store unit side, master = pipeline/memory side
interface mem_store_unit_if;
  import mem_store_unit_pkg::*;
  logic               st_valid;
  logic               st_ready;
  logic [2:0]         st_op;
  logic [REG_BUS-1:0] st_addr;
  logic [REG_BUS-1:0] st_data;
  logic               mem_w_valid;
  logic               mem_w_ready;
  logic [REG_BUS-1:0] mem_w_addr;
  logic [REG_BUS-1:0] mem_w_data;
  logic [7:0]         mem_w_mask;
  modport slave (
    input  st_valid, st_op, st_addr, st_data, mem_w_ready,
    output st_ready, mem_w_valid, mem_w_addr, mem_w_data, mem_w_mask
  );
  modport master (
    output st_valid, st_op, st_addr, st_data, mem_w_ready,
    input  st_ready, mem_w_valid, mem_w_addr, mem_w_data, mem_w_mask
  );
endinterface

// File: rtl/mem_store_unit_st_fmt.sv
// mem_store_unit_st_fmt: store legality/alignment check, byte mask and lane shift
// op/addr/data in; legal, aligned, formatted entry {aligned addr, data, mask} out
module mem_store_unit_st_fmt
  import mem_store_unit_pkg::*;
(
  input  logic [2:0]         op,
  input  logic [REG_BUS-1:0] addr,
  input  logic [REG_BUS-1:0] data,
  output logic               legal,
  output logic               aligned,
  output sb_entry_t          entry
);
  logic [2:0]         sh;
  logic [7:0]         base;
  logic [REG_BUS-1:0] size_mask;
  always_comb begin
    sh = addr[2:0];
    legal = op inside {SZ_B, SZ_H, SZ_W, SZ_D};
    base = op == SZ_B ? 8'h01 : op == SZ_H ? 8'h03 : op == SZ_W ? 8'h0f : 8'hff;
    size_mask = op == SZ_B ? 64'hff : op == SZ_H ? 64'hffff : op == SZ_W ? 64'hffff_ffff : ~ZERO_WORD;
    aligned = op == SZ_B || (op == SZ_H && !addr[0]) || (op == SZ_W && addr[1:0] == 2'b00) || (op == SZ_D && sh == 3'b000);
    entry.addr = {addr[REG_BUS-1:3], 3'b000};
    entry.data = (data & size_mask) << {sh, 3'b000};
    entry.mask = base << sh;
  end
endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: store buffer FIFO that formats stores and drains them to a 64-bit write port
// clk, rst (async active-low); bus: st_* request and mem_w_* write handshakes;
// misalign/op_err: one-cycle drop pulses; sb_empty/sb_count: buffer occupancy
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_store_unit_if.slave  bus,
  output logic             misalign,
  output logic             op_err,
  output logic             sb_empty,
  output logic [CNT_W-1:0] sb_count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  sb_entry_t        sb_q [DEPTH];
  sb_entry_t        fmt;
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    wp, rp;
  logic             legal, aligned, hs, push, pop;
  mem_store_unit_st_fmt u_fmt (
    .op      (bus.st_op),
    .addr    (bus.st_addr),
    .data    (bus.st_data),
    .legal   (legal),
    .aligned (aligned),
    .entry   (fmt)
  );
  // Ready depends only on registered count, so a same-cycle pop never frees a slot early
  assign bus.st_ready = count < CNT_W'(DEPTH);
  assign hs = bus.st_valid && bus.st_ready;
  assign push = hs && legal && aligned;
  assign pop = bus.mem_w_valid && bus.mem_w_ready;
  assign bus.mem_w_valid = count != '0;
  assign {bus.mem_w_addr, bus.mem_w_data, bus.mem_w_mask} = sb_q[rp];
  assign sb_empty = count == '0;
  assign sb_count = count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      wp <= '0;
      rp <= '0;
      misalign <= 1'b0;
      op_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        sb_q[wp] <= fmt;
        wp <= wp + 1'b1;
      end
      rp <= pop ? rp + 1'b1 : rp;
      misalign <= hs && legal && !aligned;
      op_err <= hs && !legal;
    end
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: randomized and directed bench for mem_store_unit against a queue model
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic misalign, op_err, sb_empty;
  logic [CNT_W-1:0] sb_count;
  int vectors = 0;
  int miscompares = 0;
  mem_store_unit_if bus ();
  mem_store_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .misalign (misalign),
    .op_err   (op_err),
    .sb_empty (sb_empty),
    .sb_count (sb_count)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } exp_t;
  exp_t q[$];
  logic exp_mis = 1'b0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    case (op)
      3'b001: return 1;
      3'b010: return 2;
      3'b011: return 4;
      3'b111: return 8;
      default: return 0;
    endcase
  endfunction

  // Byte-by-byte placement: byte k of the source lands in lane sh+k
  function automatic exp_t fmt(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    int sh = int'(a[2:0]);
    int n = nbytes(op);
    e.addr = {a[63:3], 3'b000};
    e.data = '0;
    e.mask = '0;
    for (int i = 0; i < 8; i++)
      if (i >= sh && i < sh + n) begin
        e.mask[i] = 1'b1;
        e.data[8*i +: 8] = d[8*(i-sh) +: 8];
      end
    return e;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit hs, pp, al;
    int n;
    if (!rst) begin
      q.delete();
      exp_mis = 1'b0;
      exp_err = 1'b0;
    end else begin
      hs = bus.st_valid && q.size() < DEPTH;
      pp = q.size() != 0 && bus.mem_w_ready;
      n = nbytes(bus.st_op);
      al = n == 0 ? 1'b0 : (int'(bus.st_addr[2:0]) % n) == 0;
      exp_err = hs && n == 0;
      exp_mis = hs && n != 0 && !al;
      if (pp) void'(q.pop_front());
      if (hs && al) q.push_back(fmt(bus.st_op, bus.st_addr, bus.st_data));
    end
  end

  always @(negedge clk)
    if (rst) begin
      chk("mem_w_valid", 64'(bus.mem_w_valid), 64'(q.size() != 0));
      chk("st_ready", 64'(bus.st_ready), 64'(q.size() < DEPTH));
      chk("sb_count", 64'(sb_count), 64'(q.size()));
      chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
      chk("misalign", 64'(misalign), 64'(exp_mis));
      chk("op_err", 64'(op_err), 64'(exp_err));
      if (q.size() != 0) begin
        chk("mem_w_addr", bus.mem_w_addr, q[0].addr);
        chk("mem_w_data", bus.mem_w_data, q[0].data);
        chk("mem_w_mask", 64'(bus.mem_w_mask), 64'(q[0].mask));
      end
    end

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    bus.st_valid = 1'b1;
    bus.st_op = op;
    bus.st_addr = a;
    bus.st_data = d;
    while (!bus.st_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.st_ready) chk("send_timeout", 64'(bus.st_ready), 64'd1);
    @(negedge clk);
    bus.st_valid = 1'b0;
  endtask

  logic [2:0] lg [4] = '{3'b001, 3'b010, 3'b011, 3'b111};
  logic [2:0] il [4] = '{3'b000, 3'b100, 3'b101, 3'b110};

  initial begin
    bus.st_valid = 1'b0;
    bus.st_op = '0;
    bus.st_addr = '0;
    bus.st_data = '0;
    bus.mem_w_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.mem_w_valid), 64'd0);
    chk("rst_addr", bus.mem_w_addr, 64'd0);
    chk("rst_data", bus.mem_w_data, 64'd0);
    chk("rst_mask", 64'(bus.mem_w_mask), 64'd0);
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_ready", 64'(bus.st_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    send(3'b001, 64'h1005, 64'hAB);
    chk("byte_valid", 64'(bus.mem_w_valid), 64'd1);
    chk("byte_addr", bus.mem_w_addr, 64'h1000);
    chk("byte_mask", 64'(bus.mem_w_mask), 64'h20);
    chk("byte_data", bus.mem_w_data, 64'h0000_AB00_0000_0000);
    @(negedge clk);
    chk("byte_drained", 64'(sb_empty), 64'd1);
    send(3'b011, 64'h2004, 64'hFFFF_FFFF_1122_3344);
    chk("word_mask", 64'(bus.mem_w_mask), 64'hF0);
    chk("word_data", bus.mem_w_data, 64'h1122_3344_0000_0000);
    @(negedge clk);
    send(3'b010, 64'h3003, 64'h1234);
    chk("mis_pulse", 64'(misalign), 64'd1);
    chk("mis_count", 64'(sb_count), 64'd0);
    chk("mis_valid", 64'(bus.mem_w_valid), 64'd0);
    @(negedge clk);
    chk("mis_clear", 64'(misalign), 64'd0);
    send(3'b100, 64'h4000, 64'h55);
    chk("err_pulse", 64'(op_err), 64'd1);
    chk("err_nomis", 64'(misalign), 64'd0);
    chk("err_valid", 64'(bus.mem_w_valid), 64'd0);
    @(negedge clk);
    chk("err_clear", 64'(op_err), 64'd0);
    bus.mem_w_ready = 1'b0;
    send(3'b111, 64'h5000, 64'hAAAA_0000_0000_000A);
    send(3'b111, 64'h5008, 64'hBBBB_0000_0000_000B);
    chk("full_count", 64'(sb_count), 64'd2);
    chk("full_ready", 64'(bus.st_ready), 64'd0);
    bus.st_valid = 1'b1;
    bus.st_op = 3'b111;
    bus.st_addr = 64'h5010;
    bus.st_data = 64'hCCCC_0000_0000_000C;
    repeat (2) @(negedge clk);
    chk("stall_addr", bus.mem_w_addr, 64'h5000);
    chk("stall_data", bus.mem_w_data, 64'hAAAA_0000_0000_000A);
    bus.mem_w_ready = 1'b1;
    send(3'b111, 64'h5010, 64'hCCCC_0000_0000_000C);
    chk("c_third_addr", bus.mem_w_addr, 64'h5010);
    chk("c_third_count", 64'(sb_count), 64'd1);
    @(negedge clk);
    bus.mem_w_ready = 1'b0;
    send(3'b111, 64'h6000, 64'h1);
    send(3'b011, 64'h6008, 64'h2);
    chk("pre_rst_count", 64'(sb_count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.mem_w_valid), 64'd0);
    chk("rst_mid_count", 64'(sb_count), 64'd0);
    chk("rst_mid_ready", 64'(bus.st_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_w_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale", 64'(bus.mem_w_valid), 64'd0);
    end
    repeat (600) begin
      @(negedge clk);
      bus.st_valid = $urandom_range(0, 99) < 60;
      bus.st_op = $urandom_range(0, 9) < 8 ? lg[$urandom_range(0, 3)] : il[$urandom_range(0, 3)];
      bus.st_addr = {$urandom, $urandom};
      bus.st_data = {$urandom, $urandom};
      bus.mem_w_ready = $urandom_range(0, 99) < 50;
    end
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.mem_w_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("final_empty", 64'(sb_empty), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Store-side counterpart of the load writeback path.
- Takes store requests from the MEM stage (op code, byte address, rs2 data) and checks alignment.
- Lane-aligns data and builds an 8-bit byte mask against a 64-bit doubleword memory port.
- Buffers requests in a small FIFO and drains them to data memory over a valid/ready handshake. Back-pressure to the pipeline is via st_ready.

Parameters:
- DEPTH, 2, store buffer entries; power of two, 2..8
- CNT_W, 2, width of sb_count; must hold 0..DEPTH (DEPTH=2 → 2, DEPTH=4 → 3)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- st_valid  in  1  store request valid
- st_ready  out  1  buffer can accept
- st_op  in  3  store size, same encoding as the load path: 001 byte, 010 half, 011 word, 111 dword; all other codes illegal
- st_addr  in  64  byte address
- st_data  in  64  rs2 data, value in low bits
- mem_w_valid  out  1  write request valid
- mem_w_ready  in  1  memory accepts write
- mem_w_addr  out  64  {st_addr[63:3], 3'b000}
- mem_w_data  out  64  lane-aligned data
- mem_w_mask  out  8  byte strobes
- misalign  out  1  1-cycle pulse: misaligned store dropped
- op_err  out  1  1-cycle pulse: illegal st_op dropped
- sb_empty  out  1  buffer empty (fence/drain indication)
- sb_count  out  CNT_W  occupied entries

Behaviour:
- Reset (rst=0, async): count, read and write pointers, misalign, op_err = 0; all entry storage = 0.
  - Result: mem_w_valid=0, mem_w_addr/data/mask=0, sb_empty=1, st_ready=1.
  - Reset mid-drain discards all entries; there is no partial write.
- Accept:
  - st_ready = (count < DEPTH), purely from registered count.
  - No pass-through when full: a pop in the same cycle does not raise st_ready.
  - Handshake occurs when st_valid && st_ready.
- Alignment check on an accepted request:
  - byte: always aligned
  - half: st_addr[0]==0
  - word: st_addr[1:0]==0
  - dword: st_addr[2:0]==0
- Error handling on an accepted request:
  - Illegal op: not enqueued; op_err=1 next cycle only.
  - Legal op, misaligned: not enqueued; misalign=1 next cycle only.
  - Illegal op takes priority: misalign is not raised together with op_err.
- Formatting, with sh = st_addr[2:0]:
  - Mask base: byte 0x01, half 0x03, word 0x0F, dword 0xFF.
  - mem_w_mask = base << sh (within 8 bits).
  - mem_w_data = (st_data AND size mask) << (8*sh); bytes outside the mask are 0.
  - Formatting is computed at enqueue and stored in the entry {addr_aligned, data, mask}.
- Drain:
  - mem_w_valid = (count != 0); outputs are taken directly from the head entry.
  - Latency: a store pushed into an empty buffer gives mem_w_valid=1 on the next edge.
  - While mem_w_valid && !mem_w_ready, addr/data/mask stay stable.
  - A pop occurs on mem_w_valid && mem_w_ready; the read pointer advances and wraps at DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers: write pointer wraps modulo DEPTH, with no overflow because of the st_ready rule.
- Order: strict FIFO; no merging or forwarding.
- sb_empty = (count==0); sb_count = count.

Decomposition:
- Shared defines: store op codes (SZ_B 3'b001, SZ_H 3'b010, SZ_W 3'b011, SZ_D 3'b111), ZERO_WORD, REG_BUS width.
- Sub-module st_fmt: combinational alignment check, mask and lane shift. It is reusable by a later store-to-load forwarding check.
- The FIFO, pointers and pulse registers live in mem_store_unit.

Test Plan:
- Store byte 0xAB at addr 0x1005, mem_w_ready=1:
  - next cycle mem_w_valid=1, mem_w_addr=0x1000, mem_w_mask=0x20, mem_w_data=0x0000_AB00_0000_0000.
  - following cycle sb_empty=1.
- Store word 0x1122_3344 at 0x2004 with st_data upper bits 0xFFFF_FFFF:
  - mask=0xF0, data=0x1122_3344_0000_0000; upper garbage is removed.
- Store half at 0x3003: handshake completes, no enqueue, misalign=1 for one cycle, sb_count stays 0.
- Store op 3'b100 at 0x4000: op_err pulse only; no misalign, no write.
- mem_w_ready=0, push three dword stores A, B, C:
  - A and B accepted; st_ready=0 at count=2; C held.
  - Raise ready: writes appear in order A, B.
  - C is accepted only after count<2, and is written third.
- Reset during a stall: two entries, mem_w_ready=0, assert rst=0 mid-cycle:
  - immediately mem_w_valid=0, sb_count=0, st_ready=1.
  - after release, no stale writes occur.
